frame_cfg_scheduler: RTL and testbench
======================================

FRAME_CFG_SCHEDULER -- requirements
Module: frame_cfg_scheduler

Interface
REQ-001 SHALL have parameter SAMPLE_RST, default 8'h01, reset value of cfg_sample.
REQ-002 SHALL have parameter COLOR_RST, default 6'h00, reset value of cfg_color.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ssel_active  input  1  SPI transaction in progress, already synchronised to clk.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe: rx_byte holds a complete received SPI byte.
REQ-007 SHALL have port rx_byte  input  8  received byte.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse at h_count==0, v_count==0.
REQ-009 SHALL have port cfg_color  output  6  active pixel colour {r,g,b}.
REQ-010 SHALL have port cfg_sample  output  8  active PWM sample.
REQ-011 SHALL have port cfg_mode  output  2  active display mode.
REQ-012 SHALL have port cfg_audio_en  output  1  active audio-source enable.
REQ-013 SHALL have port tx_byte  output  8  readback byte for the SPI shifter.
REQ-014 SHALL have port tx_load  output  1  one-cycle strobe: load tx_byte into the SPI shifter.
REQ-015 SHALL have port err  output  1  one-cycle pulse: access to an illegal address.

Function
REQ-016 SHALL hold a register map: addr 0 colour[5:0], 1 sample[7:0], 2 mode[1:0], 3 ctrl (bit0 audio_en); unused bits write-ignored and read 0.
REQ-017 SHALL keep a shadow copy and an active copy of every register; the cfg_* outputs SHALL drive only the active copy.
REQ-018 SHALL implement a parser FSM with states IDLE, CMD, WDATA, RDATA and DROP.
REQ-019 IDLE->CMD when ssel_active rises; any state->IDLE on the cycle after ssel_active is low.
REQ-020 In CMD, the first rx_valid byte SHALL be decoded as bit7=1 write, bit7=0 read, bits[6:0]=address.
REQ-021 Address >=4 SHALL go to DROP, pulse err one cycle later, and ignore all bytes until ssel_active falls.
REQ-022 In WDATA, each rx_valid byte SHALL write shadow[addr] and then post-increment addr; a write after addr 3 SHALL go to DROP with err.
REQ-023 Each completed write SHALL set a pending flag; a lone command byte or an aborted transaction SHALL NOT set it; completed data bytes SHALL be kept.
REQ-024 Commit SHALL copy all shadow registers to active in the cycle after frame_start, only when pending=1 and ssel_active=0; commit SHALL clear pending.
REQ-025 A frame_start during an active transaction SHALL defer the commit to the next qualifying frame_start, so a multi-byte update applies atomically.
REQ-026 If a shadow write and a commit occur in the same cycle, the commit SHALL use the pre-write shadow value, and pending SHALL remain set.
REQ-027 Address arithmetic SHALL be 2-bit with an explicit overflow check; it SHALL never wrap to 0.

Reset
REQ-028 On rst_n low, the active and shadow registers SHALL take the values: colour=COLOR_RST, sample=SAMPLE_RST, mode=0, ctrl=0.
REQ-029 On rst_n low: FSM=IDLE, pending=0, tx_byte=0, tx_load=0, err=0; a reset mid-transaction SHALL discard it.

Configuration
REQ-030 With READBACK_EN defined: in RDATA, tx_byte=active[addr] and tx_load SHALL pulse one cycle after the command byte and after each later rx_valid, with addr post-incremented; a read past addr 3 SHALL go to DROP with err.
REQ-031 Without READBACK_EN: a read command SHALL go to DROP with err, tx_byte SHALL be tied to 0 and tx_load to 0.

Structure
REQ-032 Register addresses, the reset constants, the FSM state encoding and the command bit positions SHALL live in the shared package frame_cfg_pkg.
REQ-033 The shadow/active register bank with commit logic SHALL be one sub-module, cfg_regbank; the parser FSM SHALL remain in frame_cfg_scheduler.

Verification
REQ-034 Reset: after reset release, cfg_sample=8'h01, cfg_color=0, cfg_mode=0, cfg_audio_en=0, tx_load=0.
REQ-035 Write burst: bytes 0x80,0x2A,0x55 then ssel_active low, then frame_start -> cfg_color=6'h2A and cfg_sample=8'h55 on the cycle after frame_start, not before.
REQ-036 Deferred commit: frame_start while ssel_active=1 mid-burst -> outputs unchanged; the next frame_start with ssel_active=0 commits.
REQ-037 Illegal access: command byte 0x85 -> err pulses once; following bytes are ignored; pending stays 0.
REQ-038 Readback (READBACK_EN): after committing sample=0x55, command 0x01 -> tx_load pulses with tx_byte=0x55; next byte -> tx_byte=mode; without READBACK_EN -> err pulses and tx_load stays 0.
REQ-039 Abort/reset: rst_n low between the command byte and the data byte -> all values return to reset; a subsequent frame_start commits nothing.

Source files
------------

// File: rtl/frame_cfg_pkg.sv
// Shared definitions for frame_cfg_scheduler and cfg_regbank.
// Contents: register addresses, reset constants, parser state encoding,
// command byte layout, the register bank payload and its read/write helpers.
package frame_cfg_pkg;

    localparam int unsigned NUM_REGS    = 4;
    localparam int unsigned ADDR_W      = 2;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned COLOR_W     = 6;
    localparam int unsigned MODE_W      = 2;

    localparam logic [ADDR_W-1:0] ADDR_COLOR  = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_SAMPLE = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_MODE   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd3;

    localparam logic [DATA_W-1:0]  SAMPLE_RST_DEF = 8'h01;
    localparam logic [COLOR_W-1:0] COLOR_RST_DEF  = 6'h00;

    // Command byte: bit7 selects write, bits[6:0] carry the start address
    localparam int unsigned CMD_WR_BIT   = 7;
    localparam int unsigned CMD_ADDR_MSB = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DROP  = 3'd4
    } state_e;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [DATA_W-1:0]  sample;
        logic [MODE_W-1:0]  mode;
        logic               audio_en;
    } cfg_regs_t;

    // Register view as seen on the bus; unused bits read as 0
    function automatic logic [DATA_W-1:0] reg_read(input cfg_regs_t r, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        case (a)
            ADDR_COLOR:  v = {2'b00, r.color};
            ADDR_SAMPLE: v = r.sample;
            ADDR_MODE:   v = {6'b000000, r.mode};
            default:     v = {7'b0000000, r.audio_en};
        endcase
        return v;
    endfunction

    // Bus write into one register; unused bits are dropped
    function automatic cfg_regs_t reg_write(input cfg_regs_t r, input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] d);
        cfg_regs_t v;
        v = r;
        case (a)
            ADDR_COLOR:  v.color    = d[COLOR_W-1:0];
            ADDR_SAMPLE: v.sample   = d;
            ADDR_MODE:   v.mode     = d[MODE_W-1:0];
            default:     v.audio_en = d[0];
        endcase
        return v;
    endfunction

    // Saturating post-increment: returns {overflow, next_addr}; never wraps to 0
    function automatic logic [ADDR_W:0] addr_inc(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] v;
        if (a == ADDR_CTRL) v = {1'b1, a};
        else                v = {1'b0, ADDR_W'(a + 2'd1)};
        return v;
    endfunction

endpackage

// File: rtl/cfg_regbank.sv
// Shadow/active configuration register bank with frame-synchronous commit.
// Ports: clk, rst_n; wr_en/wr_addr/wr_data write the shadow copy;
// frame_start + ssel_active qualify the commit; active_o is the live copy.
module cfg_regbank
    import frame_cfg_pkg::*;
#(
    parameter logic [7:0] SAMPLE_RST = SAMPLE_RST_DEF,
    parameter logic [5:0] COLOR_RST  = COLOR_RST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              frame_start,
    input  logic              ssel_active,
    output cfg_regs_t         active_o
);

    localparam cfg_regs_t RST_VAL = {COLOR_RST, SAMPLE_RST, 2'b00, 1'b0};

    cfg_regs_t shadow_q, shadow_d;
    cfg_regs_t active_q, active_d;
    logic      pending_q, pending_d;
    logic      commit_c;

    // Commit only between transactions so a multi-byte update lands atomically
    assign commit_c = frame_start && pending_q && !ssel_active;

    // Commit copies the pre-write shadow; a same-cycle write keeps pending set
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (commit_c) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (wr_en) begin
            shadow_d  = reg_write(shadow_q, wr_addr, wr_data);
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= RST_VAL;
            active_q  <= RST_VAL;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/frame_cfg_scheduler.sv
// SPI-driven configuration scheduler: parses command/data bytes into a
// shadow register bank and commits them to the active copy at frame start.
// Ports: clk, rst_n, ssel_active, rx_valid, rx_byte, frame_start in;
// cfg_color, cfg_sample, cfg_mode, cfg_audio_en, tx_byte, tx_load, err out.
// Build option: define READBACK_EN to enable register readback over SPI;
// otherwise read commands are rejected with err and tx_* are tied to 0.
module frame_cfg_scheduler
    import frame_cfg_pkg::*;
#(
    parameter logic [7:0] SAMPLE_RST = SAMPLE_RST_DEF,
    parameter logic [5:0] COLOR_RST  = COLOR_RST_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ssel_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       frame_start,
    output logic [5:0] cfg_color,
    output logic [7:0] cfg_sample,
    output logic [1:0] cfg_mode,
    output logic       cfg_audio_en,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic       err
);

    state_e            state_q, state_d;
    logic              ssel_prev_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_ovf_q, addr_ovf_d;
    logic              err_q, err_d;
    logic              wr_en_c;
    cfg_regs_t         active;
`ifdef READBACK_EN
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic              tx_load_q, tx_load_d;
`endif

    cfg_regbank #(
        .SAMPLE_RST (SAMPLE_RST),
        .COLOR_RST  (COLOR_RST)
    ) u_regbank (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en_c),
        .wr_addr     (addr_q),
        .wr_data     (rx_byte),
        .frame_start (frame_start),
        .ssel_active (ssel_active),
        .active_o    (active)
    );

    // Parser next-state and strobe logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        addr_ovf_d = addr_ovf_q;
        err_d      = 1'b0;
        wr_en_c    = 1'b0;
`ifdef READBACK_EN
        tx_byte_d  = tx_byte_q;
        tx_load_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ssel_active && !ssel_prev_q) begin
                    state_d    = ST_CMD;
                    addr_d     = '0;
                    addr_ovf_d = 1'b0;
                end
            end
            ST_CMD: begin
                if (rx_valid) begin
                    if (rx_byte[CMD_ADDR_MSB:0] >= 7'(NUM_REGS)) begin
                        state_d = ST_DROP;
                        err_d   = 1'b1;
                    end else if (rx_byte[CMD_WR_BIT]) begin
                        state_d    = ST_WDATA;
                        addr_d     = rx_byte[ADDR_W-1:0];
                        addr_ovf_d = 1'b0;
                    end else begin
`ifdef READBACK_EN
                        state_d                = ST_RDATA;
                        tx_load_d              = 1'b1;
                        tx_byte_d              = reg_read(active, rx_byte[ADDR_W-1:0]);
                        {addr_ovf_d, addr_d}   = addr_inc(rx_byte[ADDR_W-1:0]);
`else
                        state_d = ST_DROP;
                        err_d   = 1'b1;
`endif
                    end
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    if (addr_ovf_q) begin
                        state_d = ST_DROP;
                        err_d   = 1'b1;
                    end else begin
                        wr_en_c              = 1'b1;
                        {addr_ovf_d, addr_d} = addr_inc(addr_q);
                    end
                end
            end
`ifdef READBACK_EN
            ST_RDATA: begin
                if (rx_valid) begin
                    if (addr_ovf_q) begin
                        state_d = ST_DROP;
                        err_d   = 1'b1;
                    end else begin
                        tx_load_d            = 1'b1;
                        tx_byte_d            = reg_read(active, addr_q);
                        {addr_ovf_d, addr_d} = addr_inc(addr_q);
                    end
                end
            end
`endif
            ST_DROP: ;
            default: state_d = ST_IDLE;
        endcase
        // Deselect terminates any transaction
        if (!ssel_active) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ssel_prev_q <= 1'b0;
            addr_q      <= '0;
            addr_ovf_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef READBACK_EN
            tx_byte_q   <= '0;
            tx_load_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ssel_prev_q <= ssel_active;
            addr_q      <= addr_d;
            addr_ovf_q  <= addr_ovf_d;
            err_q       <= err_d;
`ifdef READBACK_EN
            tx_byte_q   <= tx_byte_d;
            tx_load_q   <= tx_load_d;
`endif
        end
    end

    assign cfg_color    = active.color;
    assign cfg_sample   = active.sample;
    assign cfg_mode     = active.mode;
    assign cfg_audio_en = active.audio_en;
    assign err          = err_q;
`ifdef READBACK_EN
    assign tx_byte      = tx_byte_q;
    assign tx_load      = tx_load_q;
`else
    assign tx_byte      = 8'h00;
    assign tx_load      = 1'b0;
`endif

endmodule

// File: tb/tb_frame_cfg_scheduler.sv
// Directed testbench for frame_cfg_scheduler.
module tb_frame_cfg_scheduler;

    logic       clk;
    logic       rst_n;
    logic       ssel_active;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       frame_start;
    logic [5:0] cfg_color;
    logic [7:0] cfg_sample;
    logic [1:0] cfg_mode;
    logic       cfg_audio_en;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       err;

    int n_tests;
    int n_fail;

    frame_cfg_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ssel_active  (ssel_active),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .frame_start  (frame_start),
        .cfg_color    (cfg_color),
        .cfg_sample   (cfg_sample),
        .cfg_mode     (cfg_mode),
        .cfg_audio_en (cfg_audio_en),
        .tx_byte      (tx_byte),
        .tx_load      (tx_load),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_txn();
        ssel_active = 1'b1;
        tick();
        tick();
    endtask

    task automatic end_txn();
        ssel_active = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++; if (cfg_sample !== 8'h01) begin n_fail++; $display("FAIL reset_sample got %h exp 01", cfg_sample); end
        n_tests++; if (cfg_color !== 6'h00) begin n_fail++; $display("FAIL reset_color got %h exp 00", cfg_color); end
        n_tests++; if (cfg_mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode got %h exp 0", cfg_mode); end
        n_tests++; if (cfg_audio_en !== 1'b0) begin n_fail++; $display("FAIL reset_audio got %b exp 0", cfg_audio_en); end
        n_tests++; if (tx_load !== 1'b0) begin n_fail++; $display("FAIL reset_tx_load got %b exp 0", tx_load); end
        n_tests++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte got %h exp 00", tx_byte); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    endtask

    task automatic test_write_burst();
        begin_txn();
        send_byte(8'h80);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL wb_cmd_err got %b exp 0", err); end
        send_byte(8'h2A);
        send_byte(8'h55);
        end_txn();
        tick();
        n_tests++; if (cfg_color !== 6'h00) begin n_fail++; $display("FAIL wb_color_early got %h exp 00", cfg_color); end
        n_tests++; if (cfg_sample !== 8'h01) begin n_fail++; $display("FAIL wb_sample_early got %h exp 01", cfg_sample); end
        pulse_frame();
        n_tests++; if (cfg_color !== 6'h2A) begin n_fail++; $display("FAIL wb_color got %h exp 2a", cfg_color); end
        n_tests++; if (cfg_sample !== 8'h55) begin n_fail++; $display("FAIL wb_sample got %h exp 55", cfg_sample); end
    endtask

    task automatic test_deferred_commit();
        begin_txn();
        send_byte(8'h82);
        send_byte(8'h03);
        pulse_frame();
        send_byte(8'h01);
        n_tests++; if (cfg_mode !== 2'd0) begin n_fail++; $display("FAIL def_mode_mid got %h exp 0", cfg_mode); end
        n_tests++; if (cfg_audio_en !== 1'b0) begin n_fail++; $display("FAIL def_audio_mid got %b exp 0", cfg_audio_en); end
        end_txn();
        tick();
        n_tests++; if (cfg_mode !== 2'd0) begin n_fail++; $display("FAIL def_mode_wait got %h exp 0", cfg_mode); end
        pulse_frame();
        n_tests++; if (cfg_mode !== 2'd3) begin n_fail++; $display("FAIL def_mode got %h exp 3", cfg_mode); end
        n_tests++; if (cfg_audio_en !== 1'b1) begin n_fail++; $display("FAIL def_audio got %b exp 1", cfg_audio_en); end
    endtask

    task automatic test_addr_overflow();
        begin_txn();
        send_byte(8'h83);
        send_byte(8'h00);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_early got %b exp 0", err); end
        send_byte(8'hFF);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b exp 1", err); end
        tick();
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_once got %b exp 0", err); end
        end_txn();
        pulse_frame();
        n_tests++; if (cfg_audio_en !== 1'b0) begin n_fail++; $display("FAIL ovf_audio got %b exp 0", cfg_audio_en); end
        n_tests++; if (cfg_color !== 6'h2A) begin n_fail++; $display("FAIL ovf_nowrap_color got %h exp 2a", cfg_color); end
        n_tests++; if (cfg_mode !== 2'd3) begin n_fail++; $display("FAIL ovf_mode got %h exp 3", cfg_mode); end
    endtask

    task automatic test_illegal();
        begin_txn();
        send_byte(8'h85);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err got %b exp 1", err); end
        tick();
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_err_once got %b exp 0", err); end
        send_byte(8'h00);
        send_byte(8'h11);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_err_quiet got %b exp 0", err); end
        end_txn();
        pulse_frame();
        n_tests++; if (cfg_color !== 6'h2A) begin n_fail++; $display("FAIL ill_color got %h exp 2a", cfg_color); end
        n_tests++; if (cfg_sample !== 8'h55) begin n_fail++; $display("FAIL ill_sample got %h exp 55", cfg_sample); end
    endtask

    task automatic test_readback();
        begin_txn();
        send_byte(8'h01);
`ifdef READBACK_EN
        n_tests++; if (tx_load !== 1'b1) begin n_fail++; $display("FAIL rb_load0 got %b exp 1", tx_load); end
        n_tests++; if (tx_byte !== 8'h55) begin n_fail++; $display("FAIL rb_byte0 got %h exp 55", tx_byte); end
        tick();
        n_tests++; if (tx_load !== 1'b0) begin n_fail++; $display("FAIL rb_load_once got %b exp 0", tx_load); end
        send_byte(8'h00);
        n_tests++; if (tx_load !== 1'b1) begin n_fail++; $display("FAIL rb_load1 got %b exp 1", tx_load); end
        n_tests++; if (tx_byte !== 8'h03) begin n_fail++; $display("FAIL rb_byte1 got %h exp 03", tx_byte); end
`else
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL rb_err got %b exp 1", err); end
        n_tests++; if (tx_load !== 1'b0) begin n_fail++; $display("FAIL rb_load got %b exp 0", tx_load); end
        tick();
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rb_err_once got %b exp 0", err); end
        send_byte(8'h00);
        n_tests++; if (tx_load !== 1'b0) begin n_fail++; $display("FAIL rb_load1 got %b exp 0", tx_load); end
        n_tests++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL rb_byte got %h exp 00", tx_byte); end
`endif
        end_txn();
    endtask

    task automatic test_write_commit_same_cycle();
        begin_txn();
        send_byte(8'h80);
        send_byte(8'h11);
        rx_byte     = 8'h77;
        rx_valid    = 1'b1;
        ssel_active = 1'b0;
        frame_start = 1'b1;
        tick();
        rx_valid    = 1'b0;
        frame_start = 1'b0;
        n_tests++; if (cfg_color !== 6'h11) begin n_fail++; $display("FAIL same_color got %h exp 11", cfg_color); end
        n_tests++; if (cfg_sample !== 8'h55) begin n_fail++; $display("FAIL same_sample_prewrite got %h exp 55", cfg_sample); end
        tick();
        pulse_frame();
        n_tests++; if (cfg_sample !== 8'h77) begin n_fail++; $display("FAIL same_sample_pending got %h exp 77", cfg_sample); end
    endtask

    task automatic test_abort_reset();
        begin_txn();
        send_byte(8'h80);
        send_byte(8'h15);
        end_txn();
        begin_txn();
        send_byte(8'h80);
        rst_n = 1'b0;
        #1;
        n_tests++; if (cfg_color !== 6'h00) begin n_fail++; $display("FAIL abort_color got %h exp 00", cfg_color); end
        n_tests++; if (cfg_sample !== 8'h01) begin n_fail++; $display("FAIL abort_sample got %h exp 01", cfg_sample); end
        ssel_active = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_frame();
        n_tests++; if (cfg_color !== 6'h00) begin n_fail++; $display("FAIL abort_commit_color got %h exp 00", cfg_color); end
        n_tests++; if (cfg_sample !== 8'h01) begin n_fail++; $display("FAIL abort_commit_sample got %h exp 01", cfg_sample); end
        n_tests++; if (cfg_mode !== 2'd0) begin n_fail++; $display("FAIL abort_commit_mode got %h exp 0", cfg_mode); end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        ssel_active = 1'b0;
        rx_valid    = 1'b0;
        rx_byte     = 8'h00;
        frame_start = 1'b0;
        test_reset();
        test_write_burst();
        test_deferred_commit();
        test_addr_overflow();
        test_illegal();
        test_readback();
        test_write_commit_same_cycle();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
